// File: rtl/wb_dest_queue_pkg.sv
// Shared constants for write-back destination selection and queueing.
// Imported by the selector, the queue and its bench.
package wb_dest_queue_pkg;

  localparam logic [1:0] WR_DST_RD = 2'b00;
  localparam logic [1:0] WR_DST_SP = 2'b01;
  localparam logic [1:0] WR_DST_RA = 2'b10;
  localparam logic [1:0] WR_DST_RT = 2'b11;

  localparam int DEF_SP_IDX = 29;
  localparam int DEF_RA_IDX = 31;

endpackage

// File: rtl/wb_dest_queue_if.sv
// Issue / retire / scoreboard-query bundle between decode and the destination queue.
// The master side drives requests and queries; the slave side is the queue.
interface wb_dest_queue_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              issue_valid;
  logic              issue_ready;
  logic [1:0]        write_reg_ctrl;
  logic [REG_AW-1:0] rd_idx;
  logic [REG_AW-1:0] rt_idx;
  logic              retire;
  logic              flush;
  logic              head_valid;
  logic [REG_AW-1:0] head_dest;
  logic [CW-1:0]     count;
  logic [REG_AW-1:0] query_a;
  logic [REG_AW-1:0] query_b;
  logic              hazard_a;
  logic              hazard_b;

  modport master (
    output issue_valid, write_reg_ctrl, rd_idx, rt_idx, retire, flush, query_a, query_b,
    input  issue_ready, head_valid, head_dest, count, hazard_a, hazard_b
  );

  modport slave (
    input  issue_valid, write_reg_ctrl, rd_idx, rt_idx, retire, flush, query_a, query_b,
    output issue_ready, head_valid, head_dest, count, hazard_a, hazard_b
  );

endinterface

// File: rtl/wb_dest_queue_dest_sel.sv
// Combinational 4:1 select of the write-back register index from the
// instruction fields and the destination control code.
module wb_dest_sel
  import wb_dest_queue_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int SP_IDX = DEF_SP_IDX,
  parameter int RA_IDX = DEF_RA_IDX
) (
  input  logic [1:0]        ctrl,
  input  logic [REG_AW-1:0] rd_idx,
  input  logic [REG_AW-1:0] rt_idx,
  output logic [REG_AW-1:0] dest
);

  // destination index decode
  always_comb begin
    dest = rd_idx;
    case (ctrl)
      WR_DST_RD: dest = rd_idx;
      WR_DST_SP: dest = REG_AW'(SP_IDX);
      WR_DST_RA: dest = REG_AW'(RA_IDX);
      WR_DST_RT: dest = rt_idx;
      default:   dest = rd_idx;
    endcase
  end

endmodule

// File: rtl/wb_dest_queue.sv
// In-order queue of in-flight register writes that doubles as a RAW scoreboard:
// every valid entry is compared against two source-index queries.
module wb_dest_queue
  import wb_dest_queue_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 4,
  parameter int SP_IDX = DEF_SP_IDX,
  parameter int RA_IDX = DEF_RA_IDX
) (
  input logic            clk,
  input logic            reset,
  wb_dest_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [REG_AW-1:0] dest_r [DEPTH];
  logic [DEPTH-1:0]  valid_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  logic [REG_AW-1:0] sel_dest_s;
  logic              head_valid_s;
  logic              pop_s;
  logic              push_s;
  logic              ready_s;
  logic              hazard_a_s;
  logic              hazard_b_s;

  wb_dest_sel #(
    .REG_AW (REG_AW),
    .SP_IDX (SP_IDX),
    .RA_IDX (RA_IDX)
  ) u_sel (
    .ctrl   (bus.write_reg_ctrl),
    .rd_idx (bus.rd_idx),
    .rt_idx (bus.rt_idx),
    .dest   (sel_dest_s)
  );

  // handshake: a same-cycle retire frees a slot, so a full queue can still accept
  always_comb begin
    head_valid_s = valid_r[rd_ptr_r];
    pop_s        = bus.retire && head_valid_s;
    ready_s      = (count_r < CW'(DEPTH)) || pop_s;
    push_s       = bus.issue_valid && ready_s && (sel_dest_s != REG_AW'(0));
  end

  // scoreboard match of both queries against registered entries only
  always_comb begin
    hazard_a_s = 1'b0;
    hazard_b_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hazard_a_s = hazard_a_s | (valid_r[i] && (dest_r[i] == bus.query_a));
      hazard_b_s = hazard_b_s | (valid_r[i] && (dest_r[i] == bus.query_b));
    end
    hazard_a_s = hazard_a_s && (bus.query_a != REG_AW'(0));
    hazard_b_s = hazard_b_s && (bus.query_b != REG_AW'(0));
  end

  // queue state: reset, then flush, then pop/push
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_r[i] <= '0;
      end
    end else if (bus.flush) begin
      valid_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      // pop is written first so a push into the slot just freed (full case) wins
      if (pop_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + PW'(1);
      end
      if (push_s) begin
        valid_r[wr_ptr_r] <= 1'b1;
        dest_r[wr_ptr_r]  <= sel_dest_s;
        wr_ptr_r          <= wr_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.issue_ready = ready_s;
  assign bus.head_valid  = head_valid_s;
  assign bus.head_dest   = head_valid_s ? dest_r[rd_ptr_r] : REG_AW'(0);
  assign bus.count       = count_r;
  assign bus.hazard_a    = hazard_a_s;
  assign bus.hazard_b    = hazard_b_s;

endmodule
